pc_sequencer: RTL
=================

# pc_sequencer

Program-counter controller for the single-cycle core. Sequences instruction fetch from Start to Halt and resolves taken branches through a small writable branch-target table, so the instruction only carries a 2-bit pointer to a 10-bit target. Sits between decode/branch-condition logic and instruction memory. It drives the fetch address and the run/done status seen by the testbench.

## Interface
- PC_W, 10, width of PC and of table entries
- PTR_W, 2, table pointer width; table depth is 2**PTR_W
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Start  in  1  pulse; begins execution from PC 0 when in IDLE or DONE
- Stall  in  1  freeze PC and state this cycle
- Halt  in  1  end of program; enter DONE
- BranchEn  in  1  branch taken this cycle (condition already resolved)
- BranchAbs  in  1  1: PC = target; 0: PC = PC + target (two's complement)
- BranchPtr  in  PTR_W  table index for the branch
- TblWrEn  in  1  write table entry
- TblWrAddr  in  PTR_W  entry written
- TblWrData  in  PC_W  value written
- PC  out  PC_W  fetch address (registered)
- Fetch  out  1  PC is a valid fetch this cycle
- Done  out  1  program finished (registered state decode)
- BranchCnt  out  16  taken-branch count (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, PC 0x000, BranchCnt 0.
- Reset table contents: entry0 0x3FF (-1), entry1 0x003, entry2 0x007, entry3 0x001.
- IDLE: Start moves to RUN with PC 0. Other control inputs are ignored.
- RUN, Stall=1: PC and state hold. Halt and BranchEn are ignored and not latched.
- RUN, Stall=0, priority Halt > BranchEn > increment:
  - Halt: move to DONE; PC holds.
  - BranchEn with BranchAbs=1: PC <= table[BranchPtr].
  - BranchEn with BranchAbs=0: PC <= PC + table[BranchPtr], truncated to PC_W bits. Entry 0x3FF therefore steps back one.
  - Otherwise: PC <= PC + 1, modulo 2**PC_W. 0x3FF wraps to 0x000.
- RUN, Start: ignored.
- DONE: PC holds and Done=1. Start returns to RUN with PC 0. Stall has no effect.
- Table writes are accepted in every state.
  - Reads are combinational from current contents.
  - A write and a branch to the same entry in the same cycle use the old value; the new value is visible from the next cycle.
- Fetch = (state==RUN) && !Stall.
- Done = (state==DONE).
- Reset asserted mid-RUN: state, PC and table return to reset values immediately, without waiting for Clk.

## Timing
- Latency of 1 cycle from a control input to the PC update; PC is valid at the clock edge after the decision.
- Branch target appears on PC in the cycle after BranchEn is sampled.
- Done rises in the cycle after Halt is sampled with Stall=0.
- Start → Fetch=1 with PC=0 in the next cycle.
- Fetch responds combinationally to Stall within the cycle. No combinational path from Stall, Halt or BranchEn to PC.
- Reset deassertion is synchronous to Clk externally. The block needs no extra synchronizer.

## Configuration
- PC_SEQ_BRANCH_CNT_EN defined:
  - BranchCnt increments on each taken branch (RUN, Stall=0, BranchEn=1, Halt=0).
  - The count saturates at 0xFFFF.
  - It clears on Reset and on each accepted Start.
- Undefined: counter logic is absent and BranchCnt is tied to 0. The port list is unchanged.

## Structure
- Package pc_seq_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - PC_W and PTR_W defaults
  - TBL_RESET array of the four reset targets
  - counter width 16
- Sub-module target_table: a 2**PTR_W × PC_W register file.
  - Asynchronous reset loads TBL_RESET.
  - One synchronous write port and one combinational read port.
- pc_sequencer instantiates target_table and holds the FSM, the PC register and the optional counter.

## Test plan
- Increment and wrap:
  - Reset, then Start pulse, no branches → PC 0,1,2,3 on consecutive cycles; Fetch=1, Done=0.
  - Run to PC 0x3FF → next PC is 0x000.
- Relative and absolute branches:
  - At PC 5, BranchEn, BranchAbs=0, ptr 0 → PC 4 next cycle.
  - Then BranchAbs=1, ptr 1 → PC 0x003.
- Stall priority: in RUN at PC 8, Stall=1 with BranchEn and Halt asserted for 3 cycles → PC stays 8, Done=0, Fetch=0. Release Stall with BranchEn, abs, ptr 2 → PC 0x007.
- Write/read collision: TblWrEn ptr 2 with data 0x100 in the same cycle as an abs branch on ptr 2 → PC 0x007. A later abs branch on ptr 2 → PC 0x100.
- Halt and restart: Halt at PC 0x010 → Done=1 next cycle; PC stays 0x010 over 5 cycles. Start → PC 0, Done=0.
- Async reset and counter:
  - With PC_SEQ_BRANCH_CNT_EN: 3 taken branches → BranchCnt 3.
  - Reset asserted mid-cycle in RUN → PC 0, Done 0, BranchCnt 0 before the next edge; ptr 2 reads 0x007 again.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types, widths and branch-target reset values for the PC sequencer.
package pc_seq_pkg;

  localparam int unsigned PC_W_DEF  = 10;
  localparam int unsigned PTR_W_DEF = 2;
  localparam int unsigned TBL_DEPTH = 1 << PTR_W_DEF;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Entry 0 is -1 so a relative branch through it steps back one instruction.
  localparam logic [TBL_DEPTH-1:0][PC_W_DEF-1:0] TBL_RESET = {
    10'h001, 10'h007, 10'h003, 10'h3FF
  };

  function automatic logic [PC_W_DEF-1:0] tbl_reset_val(input int unsigned idx);
    return TBL_RESET[idx[PTR_W_DEF-1:0]];
  endfunction

endpackage

// File: rtl/target_table.sv
// Branch-target register file: one synchronous write port, one combinational
// read port; asynchronous reset reloads the default targets.
module target_table
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned PTR_W = PTR_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [PC_W-1:0]  i_wr_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [PC_W-1:0]  o_rd_data
);

  localparam int unsigned DEPTH = 1 << PTR_W;

  logic [PC_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[PTR_W'(i)] <= PC_W'(tbl_reset_val(i));
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read sees pre-write contents, so a same-cycle write/branch uses the old value.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: IDLE/RUN/DONE FSM, PC register and branch resolution
// through target_table. Optional taken-branch counter under PC_SEQ_BRANCH_CNT_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned PTR_W = PTR_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stall,
  input  logic             i_halt,
  input  logic             i_branch_en,
  input  logic             i_branch_abs,
  input  logic [PTR_W-1:0] i_branch_ptr,
  input  logic             i_tbl_wr_en,
  input  logic [PTR_W-1:0] i_tbl_wr_addr,
  input  logic [PC_W-1:0]  i_tbl_wr_data,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_fetch_c,
  output logic             o_done,
  output logic [CNT_W-1:0] o_branch_cnt
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_tgt;
  logic            r_done;

  target_table #(
    .PC_W  (PC_W),
    .PTR_W (PTR_W)
  ) u_tbl (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_tbl_wr_en),
    .i_wr_addr (i_tbl_wr_addr),
    .i_wr_data (i_tbl_wr_data),
    .i_rd_addr (i_branch_ptr),
    .o_rd_data (w_tgt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Next state / next PC; in RUN: stall > halt > branch > increment.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
        end
      end
      S_RUN: begin
        if (!i_stall) begin
          if (i_halt) begin
            w_state_nxt = S_DONE;
          end else if (i_branch_en) begin
            w_pc_nxt = i_branch_abs ? w_tgt : (r_pc + w_tgt);
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  assign o_pc      = r_pc;
  assign o_done    = r_done;
  assign o_fetch_c = (r_state == S_RUN) && !i_stall;

`ifdef PC_SEQ_BRANCH_CNT_EN
  logic             w_cnt_inc;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] r_branch_cnt;

  assign w_cnt_inc = (r_state == S_RUN) && !i_stall && !i_halt && i_branch_en;
  assign w_cnt_clr = i_start && (r_state != S_RUN);

  // Saturating taken-branch count, cleared by each accepted Start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_branch_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_branch_cnt <= '0;
    end else if (w_cnt_inc && (r_branch_cnt != {CNT_W{1'b1}})) begin
      r_branch_cnt <= r_branch_cnt + CNT_W'(1);
    end
  end

  assign o_branch_cnt = r_branch_cnt;
`else
  assign o_branch_cnt = '0;
`endif

endmodule
